adder_op_sequencer: RTL and testbench
=====================================

// Module: adder_op_sequencer
// PURPOSE
//  Multi-byte add/subtract controller in front of the shared 8-bit adder datapath.
//  Accepts a command byte and two NBYTES-wide operands as a byte stream on an input handshake.
//  Sequences the adder LSB-first, chaining carry between bytes.
//  Returns the result bytes on an output handshake; sits between the top-level IO mux and the adder.
// PARAMETERS
//  NBYTES  2  operand/result width in bytes (>=1); operands are 8*NBYTES bits
// PORTS
//  clk        in   1  sole clock, rising edge
//  rst        in   1  asynchronous reset, active-high
//  in_valid   in   1  in_data holds a valid byte
//  in_data    in   8  command/operand byte stream
//  in_ready   out  1  block accepts in_data this cycle
//  add_a      out  8  adder operand A byte
//  add_b      out  8  adder operand B byte (post-inversion when subtracting)
//  add_cin    out  1  adder carry-in
//  add_sum    in   8  adder sum (combinational from add_a/add_b/add_cin)
//  add_cout   in   1  adder carry-out
//  out_valid  out  1  out_data holds a result byte
//  out_data   out  8  result byte, LSB first
//  out_last   out  1  marks final result byte
//  out_carry  out  1  final carry (add) / no-borrow (sub); valid when out_last
//  out_ready  in   1  consumer accepts out_data
//  busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE.
//   All outputs 0 except in_ready=1.
//   Operand/result registers, byte counter and carry register cleared.
//  Beat = cycle with valid&ready high on that interface.
//  States: IDLE -> LOAD_A -> LOAD_B -> ADD -> EMIT -> IDLE.
//   IDLE: in_ready=1. Command beat latches sub=in_data[0]; bits 7:1 ignored. -> LOAD_A.
//   LOAD_A: in_ready=1. NBYTES beats, LSB first, into A[k]. Last beat -> LOAD_B.
//   LOAD_B: in_ready=1. NBYTES beats into B[k]. Last beat -> ADD.
//   ADD: in_ready=0. Exactly NBYTES cycles, k=0..NBYTES-1.
//    add_a=A[k]; add_b = sub ? ~B[k] : B[k].
//    add_cin = (k==0) ? sub : carry_reg.
//    Each cycle: R[k]<=add_sum; carry_reg<=add_cout.
//    After k=NBYTES-1 -> EMIT.
//   EMIT: out_valid=1, out_data=R[j], out_last=(j==NBYTES-1), out_carry=carry_reg.
//    j advances only on an output beat.
//    out_valid held and out_data stable while out_ready=0.
//    Last beat -> IDLE (in_ready=1 next cycle).
//  add_a/add_b/add_cin are 0 outside ADD.
//  in_ready=0 in ADD/EMIT; in_valid there is ignored and no data is consumed.
//  Arithmetic modulo 2^(8*NBYTES); sub computes A-B as A+~B+1.
//   out_carry=1 means no borrow (A>=B).
//  Gaps: in_valid low mid-load stalls the FSM with no timeout.
//  Latency: first out_valid is NBYTES+1 cycles after the last B beat.
//  Throughput: 1+2*NBYTES in beats + NBYTES + NBYTES out beats per operation; no overlap.
//  rst asserted mid-operation: immediate return to reset state.
//   Partially loaded operands are discarded.
//   No further out_valid until a new command completes.
// TESTING (NBYTES=2, ideal combinational adder model on add_*)
//  cmd 0x00, A=0x1234, B=0x00FF -> out 0x33,0x13 (0x1333); out_last on 2nd; out_carry=0.
//  cmd 0x00, A=0xFFFF, B=0x0001 -> 0x00,0x00; out_carry=1; intermediate carry chained.
//  cmd 0x01, A=0x0001, B=0x0002 -> 0xFF,0xFF; out_carry=0.
//   Repeat with A=0x0005, B=0x0003 -> 0x02,0x00; out_carry=1.
//  out_ready low 3 cycles during EMIT -> out_valid/out_data held, no byte lost or duplicated.
//   in_valid high in ADD/EMIT -> in_ready=0, no bytes consumed.
//  in_valid gaps while loading -> same result as back-to-back loading.
//   Check first out_valid exactly 3 cycles after last B beat.
//  rst pulse after 2 operand bytes -> busy=0, in_ready=1 immediately.
//   A following full op (0x00, 0x0101+0x0202) -> 0x03,0x03 with no stale data.

Source files
------------

// File: rtl/adder_op_sequencer.sv
// Multi-byte add/subtract sequencer that drives a shared 8-bit adder byte by byte, LSB first.
// It takes a command byte and two operands as an input stream and returns result bytes on an output stream.
module adder_op_sequencer #(
  parameter int unsigned NBYTES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_carry,
  input  logic       out_ready,
  output logic       busy
);

  localparam int unsigned CntW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NBYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StAdd,
    StEmit
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sub_q;
  logic            carry_q;
  logic [7:0]      a_q [NBYTES];
  logic [7:0]      b_q [NBYTES];
  logic [7:0]      r_q [NBYTES];
  logic            cnt_last;
  logic [CntW-1:0] cnt_inc;

  assign cnt_last = (cnt_q == LastIdx);
  assign cnt_inc  = cnt_q + CntW'(1);
  assign busy     = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    add_a     = 8'h00;
    add_b     = 8'h00;
    add_cin   = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    out_carry = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = StLoadA;
          cnt_d   = '0;
        end
      end
      StLoadA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_last) begin
            state_d = StLoadB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StLoadB: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_last) begin
            state_d = StAdd;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StAdd: begin
        // Subtraction is A + ~B + 1: invert B and inject the +1 as the first carry-in.
        add_a   = a_q[cnt_q];
        add_b   = sub_q ? ~b_q[cnt_q] : b_q[cnt_q];
        add_cin = (cnt_q == '0) ? sub_q : carry_q;
        if (cnt_last) begin
          state_d = StEmit;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StEmit: begin
        out_valid = 1'b1;
        out_data  = r_q[cnt_q];
        out_last  = cnt_last;
        out_carry = carry_q;
        if (out_ready) begin
          if (cnt_last) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
        a_q[i] <= 8'h00;
        b_q[i] <= 8'h00;
        r_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && in_valid) begin
        sub_q <= in_data[0];
      end
      if (state_q == StLoadA && in_valid) begin
        a_q[cnt_q] <= in_data;
      end
      if (state_q == StLoadB && in_valid) begin
        b_q[cnt_q] <= in_data;
      end
      if (state_q == StAdd) begin
        r_q[cnt_q] <= add_sum;
        carry_q    <= add_cout;
      end
    end
  end

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Randomized scoreboard bench for adder_op_sequencer with an ideal adder on the add_* port.
// Expected bytes come from whole-word arithmetic on the operands.
module tb_adder_op_sequencer;

  localparam int unsigned NB = 2;
  localparam int unsigned W  = 8 * NB;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_carry;
  logic       out_ready;
  logic       busy;

  adder_op_sequencer #(
    .NBYTES(NB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_carry(out_carry),
    .out_ready(out_ready),
    .busy     (busy)
  );

  // Ideal combinational 8-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       carry;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         beat_cyc = 0;
  int         lat_ref = 0;
  bit         lat_pending = 0;
  bit         rand_ready = 0;
  bit         stall_req = 0;
  int         stall_cnt = 0;
  bit         hold_chk = 0;
  logic [7:0] hold_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain word arithmetic modulo 2^W; for subtract, carry means A >= B.
  task automatic push_expected(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [W:0]   s;
    bit           c;
    exp_t         x;
    if (sub) begin
      r = a - b;
      c = (a >= b);
    end else begin
      s = {1'b0, a} + {1'b0, b};
      r = s[W-1:0];
      c = s[W];
    end
    for (int j = 0; j < int'(NB); j++) begin
      x.data  = r[8*j +: 8];
      x.last  = (j == int'(NB) - 1);
      x.carry = c;
      sb.push_back(x);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following the beat.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int t;
    repeat ($urandom_range(0, max_gap)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    beat_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic send_op(input logic [7:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int max_gap, input bit junk);
    int t;
    send_byte(cmd, max_gap);
    for (int j = 0; j < int'(NB); j++) send_byte(a[8*j +: 8], max_gap);
    for (int j = 0; j < int'(NB); j++) send_byte(b[8*j +: 8], max_gap);
    push_expected(cmd[0], a, b);
    lat_ref     = beat_cyc;
    lat_pending = 1'b1;
    in_valid    = 1'b0;
    if (junk) begin
      in_valid = 1'b1;
      for (int k = 0; k <= int'(NB); k++) begin
        in_data = 8'($urandom);
        check("in_ready_while_busy", 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      in_valid = 1'b0;
    end
    t = 0;
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("op_done_timeout", 32'(busy), 32'd0);
  endtask

  // Monitor: chooses out_ready for the coming edge, then scores any output beat.
  always @(negedge clk) begin
    if (rst) begin
      hold_chk  = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (hold_chk) begin
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_out_data", 32'(out_data), 32'(hold_data));
      end
      if (stall_req && out_valid && stall_cnt == 0) begin
        stall_cnt = 3;
        stall_req = 1'b0;
      end
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      hold_chk  = out_valid && !out_ready;
      hold_data = out_data;
      if (lat_pending && out_valid) begin
        check("first_out_latency", 32'(cyc - lat_ref), 32'(NB + 1));
        lat_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_last", 32'(out_last), 32'(e.last));
          if (e.last) check("out_carry", 32'(out_carry), 32'(e.carry));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send_op(8'h00, 16'h1234, 16'h00FF, 0, 1'b0);
    send_op(8'h00, 16'hFFFF, 16'h0001, 0, 1'b1);
    send_op(8'h01, 16'h0001, 16'h0002, 0, 1'b0);
    send_op(8'h01, 16'h0005, 16'h0003, 0, 1'b1);
    stall_req = 1'b1;
    send_op(8'hFE, 16'hA5A5, 16'h5A5B, 0, 1'b1);
    send_op(8'h00, 16'h1234, 16'h00FF, 3, 1'b0);

    // Abort mid-load: reset must drop busy at once and discard the partial operand.
    send_byte(8'h00, 0);
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_op(8'h00, 16'h0101, 16'h0202, 0, 1'b0);

    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (n % 8 == 0) a = '1;
      if (n % 8 == 1) b = a;
      if (n % 8 == 2) b = '0;
      send_op(8'($urandom), a, b, 2, 1'($urandom));
    end

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
